l15_picodecoder: RTL and testbench

Request-side bridge between the PicoRV32 native memory port and the L1.5 transducer request interface. It accepts one PicoRV32 load or store at a time, converts it to an L1.5 request (rqtype, size, 40-bit address, big-endian replicated data), and holds `valid` until the L1.5 acks. It then holds the request address stable until `l15_picoencoder` returns `pico_mem_ready`. It is the transmit counterpart of `l15_picoencoder`, which consumes the L1.5 responses and the held address.

---
 rtl/l15_picodecoder_if.sv | 40 ++++
 rtl/l15_picodecoder.sv | 124 ++++++++++++
 tb/tb_l15_picodecoder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l15_picodecoder_if.sv
`default_nettype none
// ============================================================================
// Module   : l15_picodecoder_if
// Purpose  : PicoRV32 native memory port plus L1.5 request channel bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface l15_picodecoder_if;
    logic        pico_mem_valid;
    logic [31:0] pico_mem_addr;
    logic [31:0] pico_mem_wdata;
    logic [3:0]  pico_mem_wstrb;
    logic        pico_mem_ready;
    logic        l15_picodecoder_ack;

    logic        picodecoder_l15_val;
    logic [4:0]  picodecoder_l15_rqtype;
    logic        picodecoder_l15_nc;
    logic [2:0]  picodecoder_l15_size;
    logic [39:0] picodecoder_l15_address;
    logic [63:0] picodecoder_l15_data;
    logic        picodecoder_l15_threadid;
    logic        illegal_wstrb;

    modport master (
        output pico_mem_valid, pico_mem_addr, pico_mem_wdata, pico_mem_wstrb,
        output pico_mem_ready, l15_picodecoder_ack,
        input  picodecoder_l15_val, picodecoder_l15_rqtype, picodecoder_l15_nc,
        input  picodecoder_l15_size, picodecoder_l15_address, picodecoder_l15_data,
        input  picodecoder_l15_threadid, illegal_wstrb
    );

    modport slave (
        input  pico_mem_valid, pico_mem_addr, pico_mem_wdata, pico_mem_wstrb,
        input  pico_mem_ready, l15_picodecoder_ack,
        output picodecoder_l15_val, picodecoder_l15_rqtype, picodecoder_l15_nc,
        output picodecoder_l15_size, picodecoder_l15_address, picodecoder_l15_data,
        output picodecoder_l15_threadid, illegal_wstrb
    );
endinterface
`default_nettype wire

// File: rtl/l15_picodecoder.sv
`default_nettype none
// ============================================================================
// Module   : l15_picodecoder
// Purpose  : Converts one PicoRV32 load/store at a time into an L1.5 request.
// Revision : 1.0 - initial release
// ============================================================================
module l15_picodecoder #(
    parameter logic [7:0] ADDR_HI = 8'h00
) (
    input wire               clk,
    input wire               rst_n,
    l15_picodecoder_if.slave bus
);
    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] STORE_RQ  = 5'b00001;
    localparam logic [2:0] PCX_SZ_1B = 3'b000;
    localparam logic [2:0] PCX_SZ_2B = 3'b001;
    localparam logic [2:0] PCX_SZ_4B = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  dec_size;
    logic [1:0]  dec_off;
    logic        dec_illegal;
    logic        dec_load;
    logic [31:0] swapped;
    logic        unused_addr_lo;

    // Word alignment comes from the strobe pattern, never from addr[1:0].
    assign unused_addr_lo = ^bus.pico_mem_addr[1:0];

    assign dec_load = (bus.pico_mem_wstrb == 4'b0000);
    assign swapped  = {bus.pico_mem_wdata[7:0],   bus.pico_mem_wdata[15:8],
                       bus.pico_mem_wdata[23:16], bus.pico_mem_wdata[31:24]};

    always_comb begin
        dec_size    = PCX_SZ_4B;
        dec_off     = 2'b00;
        dec_illegal = 1'b0;
        case (bus.pico_mem_wstrb)
            4'b0000, 4'b1111: begin
                dec_size = PCX_SZ_4B;
            end
            4'b0011: begin
                dec_size = PCX_SZ_2B;
            end
            4'b1100: begin
                dec_size = PCX_SZ_2B;
                dec_off  = 2'b10;
            end
            4'b0001: begin
                dec_size = PCX_SZ_1B;
            end
            4'b0010: begin
                dec_size = PCX_SZ_1B;
                dec_off  = 2'b01;
            end
            4'b0100: begin
                dec_size = PCX_SZ_1B;
                dec_off  = 2'b10;
            end
            4'b1000: begin
                dec_size = PCX_SZ_1B;
                dec_off  = 2'b11;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    assign bus.picodecoder_l15_threadid = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                       <= IDLE;
            bus.picodecoder_l15_val     <= 1'b0;
            bus.picodecoder_l15_rqtype  <= 5'b00000;
            bus.picodecoder_l15_nc      <= 1'b0;
            bus.picodecoder_l15_size    <= 3'b000;
            bus.picodecoder_l15_address <= 40'd0;
            bus.picodecoder_l15_data    <= 64'd0;
            bus.illegal_wstrb           <= 1'b0;
        end else begin
            bus.illegal_wstrb <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pico_mem_valid) begin
                        bus.picodecoder_l15_val     <= 1'b1;
                        bus.picodecoder_l15_rqtype  <= dec_load ? LOAD_RQ : STORE_RQ;
                        bus.picodecoder_l15_nc      <= bus.pico_mem_addr[31];
                        bus.picodecoder_l15_size    <= dec_size;
                        bus.picodecoder_l15_address <= {ADDR_HI, bus.pico_mem_addr[31:2], dec_off};
                        bus.picodecoder_l15_data    <= dec_load ? 64'd0 : {swapped, swapped};
                        bus.illegal_wstrb           <= dec_illegal;
                        state                       <= REQ;
                    end
                end
                REQ: begin
                    // Ready racing the ack means the response already arrived; skip WAIT.
                    if (bus.l15_picodecoder_ack) begin
                        bus.picodecoder_l15_val <= 1'b0;
                        state <= bus.pico_mem_ready ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.pico_mem_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.picodecoder_l15_val <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l15_picodecoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l15_picodecoder
// Purpose  : Randomized scoreboard bench for l15_picodecoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l15_picodecoder;
    localparam logic [7:0] TB_ADDR_HI = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l15_picodecoder_if bus();

    l15_picodecoder #(.ADDR_HI(TB_ADDR_HI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  rqtype;
        logic        nc;
        logic [2:0]  size;
        logic [39:0] address;
        logic [63:0] data;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int n_run = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: size/offset follow from how many strobes are set and where.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        exp_t        m;
        int          cnt;
        int          lo;
        logic [1:0]  off;
        logic [31:0] sw;
        cnt = 0;
        lo  = 0;
        for (int k = 3; k >= 0; k--) begin
            if (s[k]) begin
                cnt++;
                lo = k;
            end
        end
        for (int k = 0; k < 4; k++) sw[31 - 8*k -: 8] = w[8*k +: 8];
        m.nc      = a[31];
        m.illegal = 1'b0;
        off       = 2'd0;
        if (cnt == 0) begin
            m.rqtype = 5'd0;
            m.size   = 3'd2;
            m.data   = 64'd0;
        end else begin
            m.rqtype = 5'd1;
            m.data   = {sw, sw};
            if (cnt == 4) begin
                m.size = 3'd2;
            end else if (cnt == 1) begin
                m.size = 3'd0;
                off    = 2'(lo);
            end else if (cnt == 2 && (lo % 2 == 0) && s[lo + 1]) begin
                m.size = 3'd1;
                off    = 2'(lo);
            end else begin
                m.size    = 3'd2;
                m.illegal = 1'b1;
            end
        end
        m.address = {TB_ADDR_HI, a & 32'hFFFF_FFFC} | 40'(off);
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        bus.pico_mem_addr  = $urandom;
        bus.pico_mem_wdata = $urandom;
        bus.pico_mem_wstrb = 4'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val"},     64'(bus.picodecoder_l15_val), 64'd0);
        check({tag, "_rqtype"},  64'(bus.picodecoder_l15_rqtype), 64'd0);
        check({tag, "_nc"},      64'(bus.picodecoder_l15_nc), 64'd0);
        check({tag, "_size"},    64'(bus.picodecoder_l15_size), 64'd0);
        check({tag, "_address"}, 64'(bus.picodecoder_l15_address), 64'd0);
        check({tag, "_data"},    bus.picodecoder_l15_data, 64'd0);
        check({tag, "_illegal"}, 64'(bus.illegal_wstrb), 64'd0);
        check({tag, "_thread"},  64'(bus.picodecoder_l15_threadid), 64'd0);
    endtask

    task automatic do_txn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                          input int ack_dly, input int rdy_dly, input bit same,
                          input bit rdy_in_req, input bit rst_wait);
        exp_t e;
        e = model(a, w, s);
        bus.pico_mem_valid = 1'b1;
        bus.pico_mem_addr  = a;
        bus.pico_mem_wdata = w;
        bus.pico_mem_wstrb = s;
        sb.push_back(e);
        tick();
        check("latency_val", 64'(bus.picodecoder_l15_val), 64'd1);
        scramble();
        for (int i = 0; i < ack_dly; i++) begin
            bus.pico_mem_ready = rdy_in_req && (i == 0);
            tick();
            bus.pico_mem_ready = 1'b0;
            check("stall_val", 64'(bus.picodecoder_l15_val), 64'd1);
            scramble();
        end
        bus.l15_picodecoder_ack = 1'b1;
        bus.pico_mem_ready      = same;
        tick();
        bus.l15_picodecoder_ack = 1'b0;
        bus.pico_mem_ready      = 1'b0;
        check("val_drop", 64'(bus.picodecoder_l15_val), 64'd0);
        if (same) begin
            bus.pico_mem_valid = 1'b0;
            check("addr_idle_same", 64'(bus.picodecoder_l15_address), 64'(e.address));
            return;
        end
        if (rst_wait) begin
            #2 rst_n = 1'b0;
            #1;
            check_all_zero("rst_wait");
            bus.pico_mem_valid = 1'b0;
            tick();
            rst_n = 1'b1;
            return;
        end
        for (int i = 0; i < rdy_dly; i++) begin
            check("wait_addr", 64'(bus.picodecoder_l15_address), 64'(e.address));
            check("wait_val", 64'(bus.picodecoder_l15_val), 64'd0);
            tick();
            scramble();
        end
        bus.pico_mem_ready = 1'b1;
        check("ready_addr", 64'(bus.picodecoder_l15_address), 64'(e.address));
        tick();
        bus.pico_mem_ready = 1'b0;
        bus.pico_mem_valid = 1'b0;
        check("addr_after_ready", 64'(bus.picodecoder_l15_address), 64'(e.address));
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                continue;
            end
            if (bus.picodecoder_l15_val) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_val: got val 1 expected no request at %0t", $time);
                end else begin
                    e = sb[0];
                    check("rqtype",  64'(bus.picodecoder_l15_rqtype), 64'(e.rqtype));
                    check("nc",      64'(bus.picodecoder_l15_nc), 64'(e.nc));
                    check("size",    64'(bus.picodecoder_l15_size), 64'(e.size));
                    check("address", 64'(bus.picodecoder_l15_address), 64'(e.address));
                    check("data",    bus.picodecoder_l15_data, e.data);
                    check("illegal_pulse", 64'(bus.illegal_wstrb), prev ? 64'd0 : 64'(e.illegal));
                    if (bus.l15_picodecoder_ack) void'(sb.pop_front());
                end
            end else begin
                check("illegal_quiet", 64'(bus.illegal_wstrb), 64'd0);
            end
            prev = bus.picodecoder_l15_val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] legal [8];
        logic [3:0] s;
        legal = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bus.pico_mem_valid      = 1'b0;
        bus.pico_mem_addr       = 32'd0;
        bus.pico_mem_wdata      = 32'd0;
        bus.pico_mem_wstrb      = 4'd0;
        bus.pico_mem_ready      = 1'b0;
        bus.l15_picodecoder_ack = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Pico ready arriving while idle must not start anything.
        bus.pico_mem_ready = 1'b1;
        tick();
        bus.pico_mem_ready = 1'b0;
        check("ready_in_idle", 64'(bus.picodecoder_l15_val), 64'd0);

        do_txn(32'h8000_0104, 32'h0,         4'b0000, 2, 2, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0000_2002, 32'h00AB_0000, 4'b0100, 0, 1, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0000_4000, 32'h1234_5678, 4'b1100, 1, 0, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0000_4003, 32'h1234_5678, 4'b1111, 0, 0, 1'b0, 1'b0, 1'b0);
        do_txn(32'h0000_6001, 32'hCAFE_F00D, 4'b0110, 5, 1, 1'b0, 1'b0, 1'b0);
        do_txn(32'h9000_0010, 32'h0102_0304, 4'b0011, 1, 0, 1'b1, 1'b0, 1'b0);
        do_txn(32'h0000_7008, 32'hA5A5_5A5A, 4'b1000, 2, 1, 1'b0, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            s = ($urandom_range(1) == 0) ? legal[$urandom_range(7)] : 4'($urandom);
            do_txn($urandom, $urandom, s, $urandom_range(3), $urandom_range(3),
                   ($urandom_range(3) == 0), ($urandom_range(1) == 1), 1'b0);
        end

        do_txn(32'h0000_1234, 32'h5555_AAAA, 4'b1111, 1, 0, 1'b0, 1'b0, 1'b1);
        do_txn(32'h0000_0010, 32'h0,         4'b0000, 1, 1, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
